// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: sequences CPU data-port accesses to peripheral slots with ready handshake and bus timeout
module periph_bus_ctrl #(
  parameter int NUM_PERI = 8,
  parameter logic [27:0] PERI_BASE = 28'h8000000,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [27:0]             data_addr,
  input  logic [1:0]              data_write_n,
  input  logic [1:0]              data_read_n,
  input  logic [31:0]             data_out,
  output logic                    data_ready,
  output logic [31:0]             data_in,
  output logic [NUM_PERI-1:0]     peri_sel,
  output logic [3:0]              peri_offset,
  output logic [1:0]              peri_write_n,
  output logic [1:0]              peri_read_n,
  output logic [31:0]             peri_wdata,
  input  logic [32*NUM_PERI-1:0]  peri_rdata,
  input  logic [NUM_PERI-1:0]     peri_ready,
  output logic                    bus_err,
  output logic [7:0]              err_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [7:0] wait_cnt;
  logic [2:0] slot;
  logic req, mapped, sel_ready;
  logic [31:0] sel_rdata;
  always_comb begin
    req = data_write_n != 2'b11 || data_read_n != 2'b11;
    mapped = data_addr[27:7] == PERI_BASE[27:7] && 32'(data_addr[6:4]) < NUM_PERI;
    sel_ready = peri_ready[slot];
    sel_rdata = peri_rdata[{slot, 5'b0} +: 32];
  end
  // Ready is checked before the timeout so a last-cycle ready completes cleanly
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      peri_sel <= '0;
      peri_write_n <= 2'b11;
      peri_read_n <= 2'b11;
      peri_offset <= '0;
      peri_wdata <= '0;
      data_ready <= 1'b0;
      data_in <= '0;
      bus_err <= 1'b0;
      err_count <= '0;
      wait_cnt <= '0;
      slot <= '0;
    end else begin
      data_ready <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          peri_offset <= data_addr[3:0];
          peri_wdata <= data_out;
          slot <= data_addr[6:4];
          wait_cnt <= '0;
          if (mapped) begin
            state <= ACCESS;
            peri_sel <= NUM_PERI'(1) << data_addr[6:4];
            peri_write_n <= data_write_n;
            peri_read_n <= data_write_n != 2'b11 ? 2'b11 : data_read_n;
          end else begin
            state <= DONE;
            data_in <= '1;
            data_ready <= 1'b1;
          end
        end
        ACCESS: if (sel_ready || wait_cnt == 8'(TIMEOUT - 1)) begin
          state <= DONE;
          data_ready <= 1'b1;
          peri_sel <= '0;
          peri_write_n <= 2'b11;
          peri_read_n <= 2'b11;
          data_in <= (sel_ready && peri_write_n == 2'b11) ? sel_rdata : '1;
          if (!sel_ready) begin
            bus_err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end else wait_cnt <= wait_cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb_periph_bus_ctrl: transaction-level randomized check of periph_bus_ctrl against a latency/data model
module tb_periph_bus_ctrl;
  localparam int NP = 6;
  localparam int TO = 15;
  localparam logic [27:0] BASE = 28'h8000000;
  logic clk = 0, rst = 1;
  logic [27:0] data_addr = '0;
  logic [1:0] data_write_n = 2'b11, data_read_n = 2'b11;
  logic [31:0] data_out = '0;
  logic data_ready, bus_err;
  logic [31:0] data_in, peri_wdata;
  logic [NP-1:0] peri_sel, peri_ready = '0;
  logic [3:0] peri_offset;
  logic [1:0] peri_write_n, peri_read_n;
  logic [32*NP-1:0] peri_rdata = '0;
  logic [7:0] err_count;
  logic [31:0] rd [NP];
  int checks = 0, errors = 0, err_model = 0;

  periph_bus_ctrl #(.NUM_PERI(NP), .PERI_BASE(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .data_in(data_in), .peri_sel(peri_sel), .peri_offset(peri_offset),
    .peri_write_n(peri_write_n), .peri_read_n(peri_read_n), .peri_wdata(peri_wdata),
    .peri_rdata(peri_rdata), .peri_ready(peri_ready), .bus_err(bus_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One core transaction; d = cycles the selected slot withholds ready (255 = never)
  task automatic run(input logic [27:0] a, input logic [1:0] wn, input logic [1:0] rn,
                     input logic [31:0] wd, input int d);
    bit mp, wr, done;
    int slot, exp_lat, c;
    logic [31:0] exp_data;
    bit exp_err;
    logic [NP-1:0] oh;
    logic [1:0] ew, er;
    wr = wn != 2'b11;
    slot = int'(a[6:4]);
    mp = a[27:7] == BASE[27:7] && slot < NP;
    for (int k = 0; k < NP; k++) begin
      rd[k] = $urandom;
      peri_rdata[32*k +: 32] = rd[k];
    end
    exp_err = 0;
    if (!mp) begin
      exp_lat = 1; exp_data = '1;
    end else if (d <= TO - 1) begin
      exp_lat = 2 + d; exp_data = wr ? 32'hFFFF_FFFF : rd[slot];
    end else begin
      exp_lat = TO + 1; exp_data = '1; exp_err = 1;
      if (err_model < 255) err_model++;
    end
    oh = mp ? NP'(1) << slot : '0;
    ew = mp ? wn : 2'b11;
    er = (mp && !wr) ? rn : 2'b11;
    data_addr = a; data_write_n = wn; data_read_n = rn; data_out = wd; peri_ready = '0;
    c = 0; done = 0;
    while (!done && c < TO + 10) begin
      @(negedge clk);
      c++;
      if (data_ready) done = 1;
      else begin
        chk("access_strobes", {peri_sel, peri_write_n, peri_read_n}, {oh, ew, er});
        if (c == 1 && mp) chk("offset_wdata", {peri_offset, peri_wdata}, {a[3:0], wd});
        peri_ready = NP'($urandom);
        if (mp) peri_ready[slot] = (c >= 1 + d);
      end
    end
    chk("latency", done ? c : 0, exp_lat);
    chk("data_in", data_in, exp_data);
    chk("bus_err", bus_err, exp_err);
    chk("err_count", err_count, err_model);
    chk("done_strobes", {peri_sel, peri_write_n, peri_read_n}, {NP'(0), 4'hF});
    data_write_n = 2'b11; data_read_n = 2'b11; peri_ready = '0;
    @(negedge clk);
    chk("pulse_len", {data_ready, bus_err}, 2'b00);
  endtask

  initial begin
    int hits;
    logic [27:0] a;
    logic [1:0] wn, rn;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {data_ready, bus_err, err_count, data_in}, '0);
    chk("rst_strobes", {peri_sel, peri_write_n, peri_read_n}, {NP'(0), 4'hF});
    rst = 0;
    @(negedge clk);
    run(28'h8000010, 2'b11, 2'b10, 32'h0, 0);
    run(28'h8000000, 2'b00, 2'b11, 32'h12, 3);
    run(28'h8000020, 2'b11, 2'b10, 32'h0, 255);
    run(28'h0001000, 2'b11, 2'b10, 32'h0, 0);
    run(28'h8000070, 2'b11, 2'b10, 32'h0, 0);
    run(28'h8000060, 2'b11, 2'b00, 32'h0, 0);
    run(28'h8000054, 2'b11, 2'b10, 32'h0, TO - 1);
    run(28'h8000034, 2'b11, 2'b10, 32'h0, TO);
    run(28'h8000048, 2'b10, 2'b10, 32'hDEADBEEF, 2);
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 4) == 0) ? 28'($urandom)
                                      : {BASE[27:7], 3'($urandom_range(0, 7)), 4'($urandom)};
      wn = 2'($urandom);
      rn = 2'($urandom);
      if (wn == 2'b11 && rn == 2'b11) rn = 2'b10;
      run(a, wn, rn, $urandom, $urandom_range(0, 18));
    end
    for (int i = 0; i < 300; i++) run(28'h8000020, 2'b11, 2'b10, 32'h0, 255);
    chk("err_saturated", err_count, 8'd255);
    data_addr = 28'h8000030; data_read_n = 2'b10; peri_ready = '0;
    repeat (5) @(negedge clk);
    chk("mid_access_sel", peri_sel, NP'(8));
    rst = 1; data_read_n = 2'b11;
    @(negedge clk);
    rst = 0;
    err_model = 0;
    chk("rst_mid_strobes", {peri_sel, peri_write_n, peri_read_n}, {NP'(0), 4'hF});
    chk("rst_mid_outputs", {data_ready, bus_err, err_count}, '0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_ready || bus_err) hits++;
    end
    chk("rst_no_pulse", hits, 0);
    run(28'h8000010, 2'b01, 2'b11, 32'h5A5A, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
